// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART definitions: receiver state encoding and the
//             oversample tick divider used by both RX and TX paths.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Receiver frame states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } uart_rx_state_t;

    // Clock cycles per oversample tick, integer-truncated. Clamped to one so a
    // very fast line rate still yields a legal (every-cycle) tick.
    function automatic int unsigned uart_tick_div(
        input int unsigned clk_freq_mhz,
        input int unsigned baud_rate,
        input int unsigned oversample
    );
        int unsigned l_div;
        l_div = (clk_freq_mhz * 32'd1000000) / (baud_rate * oversample);
        return (l_div == 32'd0) ? 32'd1 : l_div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tick_gen
//  Purpose  : Free-running oversample tick generator. Emits a one-cycle tick
//             every DIV system clocks, DIV derived from clock, baud rate and
//             oversample factor.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ = 100,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned OVERSAMPLE   = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned c_div   = uart_tick_div(CLK_FREQ_MHZ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_div - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Divider counter wrapping DIV-1 -> 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_deser
//  Purpose  : 8N1 UART receiver. Synchronizes the line, oversamples each bit,
//             decides every bit by a 3-sample mid-bit majority and presents
//             the byte on a valid/ready holding register with frame-error and
//             overrun pulses.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ = 100,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned OVERSAMPLE   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned c_samp_w = $clog2(OVERSAMPLE);
    localparam logic [c_samp_w-1:0] c_mid_lo = c_samp_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_samp_w-1:0] c_mid    = c_samp_w'(OVERSAMPLE / 2);
    localparam logic [c_samp_w-1:0] c_mid_hi = c_samp_w'(OVERSAMPLE / 2 + 1);
    localparam logic [c_samp_w-1:0] c_last   = c_samp_w'(OVERSAMPLE - 1);

    logic                r_sync_q1;
    logic                r_sync_q2;
    uart_rx_state_t      r_state;
    logic [c_samp_w-1:0] r_samp_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [1:0]          r_vote;
    logic                r_out_valid;
    logic [7:0]          r_out_data;
    logic                r_frame_err;
    logic                r_overrun;

    logic                w_tick;
    logic                w_rx;
    logic [c_samp_w-1:0] w_samp_idx;
    logic                w_majority;
    logic                w_at_vote;
    logic                w_byte_done;
    logic                w_stop_bad;

    uart_tick_gen #(
        .CLK_FREQ_MHZ (CLK_FREQ_MHZ),
        .BAUD_RATE    (BAUD_RATE),
        .OVERSAMPLE   (OVERSAMPLE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_q1 <= 1'b1;
            r_sync_q2 <= 1'b1;
        end else begin
            r_sync_q1 <= rx;
            r_sync_q2 <= r_sync_q1;
        end
    end

    assign w_rx = r_sync_q2;

    // Index of the tick being processed within the current bit (wraps per bit)
    assign w_samp_idx = (r_samp_cnt == c_last) ? '0 : r_samp_cnt + 1'b1;

    // Two mid-bit samples are stored; the third is the live value at the vote
    assign w_majority = (r_vote[1] & r_vote[0]) |
                        (r_vote[1] & w_rx)      |
                        (r_vote[0] & w_rx);

    assign w_at_vote   = w_tick && (w_samp_idx == c_mid_hi);
    assign w_byte_done = (r_state == RX_STOP) && w_at_vote &&  w_majority;
    assign w_stop_bad  = (r_state == RX_STOP) && w_at_vote && !w_majority;

    // Frame state machine: start detect, bit sampling, stop check, break wait
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RX_IDLE;
            r_samp_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_vote     <= 2'b00;
        end else if (w_tick) begin
            r_samp_cnt <= w_samp_idx;
            if ((w_samp_idx == c_mid_lo) || (w_samp_idx == c_mid)) begin
                r_vote <= {r_vote[0], w_rx};
            end
            case (r_state)
                RX_IDLE: begin
                    // The tick that first sees the line low is tick 0 of the start bit
                    r_samp_cnt <= '0;
                    if (!w_rx) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if ((w_samp_idx == c_mid_hi) && w_majority) begin
                        r_state <= RX_IDLE;
                    end else if (w_samp_idx == c_last) begin
                        r_state   <= RX_DATA;
                        r_bit_cnt <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (w_samp_idx == c_mid_hi) begin
                        r_shift <= {w_majority, r_shift[7:1]};
                    end
                    if (w_samp_idx == c_last) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                RX_STOP: begin
                    // Decide at mid-stop so a back-to-back start bit is not missed
                    if (w_samp_idx == c_mid_hi) begin
                        r_state <= w_majority ? RX_IDLE : RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    r_samp_cnt <= '0;
                    if (w_rx) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

    // Holding register with valid/ready handshake and one-cycle event pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_byte_done && r_out_valid && !out_ready;
            if (w_byte_done && (!r_out_valid || out_ready)) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_shift;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_deser
//  Purpose  : Self-checking bench for uart_rx_deser. The receiver runs at a
//             scaled line rate (96 cycles per receiver bit, 97 per sent bit)
//             so the whole run stays short; a default-parameter tick
//             generator instance confirms the 54-cycle default divider.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_deser;
    import uart_pkg::*;

    localparam int unsigned CLK_MHZ = 96;
    localparam int unsigned BAUD    = 1000000;
    localparam int unsigned OS      = 16;
    localparam int          CPB     = 97;   // sent cycles/bit vs 96 received, like 868 vs 864
    localparam int          GLITCH  = 22;   // 200 cycles at 868/bit, scaled to this bit time

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;
    logic       frame_err;
    logic       overrun;
    logic       def_tick;

    uart_rx_deser #(
        .CLK_FREQ_MHZ (CLK_MHZ),
        .BAUD_RATE    (BAUD),
        .OVERSAMPLE   (OS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    uart_tick_gen u_def_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (def_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic rand_ready = 1'b0;

    // Monitor state (written only by the monitor)
    logic [7:0] got_q[$];
    int         valid_cycles = 0;
    int         ferr_cycles = 0;
    int         ovr_cycles = 0;
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;

    // Snapshots taken by the stimulus process
    int v0, f0, o0, g0;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_bytes;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (out_valid) valid_cycles++;
            if (frame_err) ferr_cycles++;
            if (overrun)   ovr_cycles++;
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (hold_prev && out_valid) begin
                checks++;
                if (out_data !== hold_data) begin
                    failures++;
                    $display("FAIL hold_stable: got %0h expected %0h", out_data, hold_data);
                end
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send_bit(input logic b, input int cpb);
        rx = b;
        cyc(cpb);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int cpb);
        send_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) send_bit(d[i], cpb);
        send_bit(stop_bit, cpb);
        rx = 1'b1;
    endtask

    task automatic snap();
        v0 = valid_cycles;
        f0 = ferr_cycles;
        o0 = ovr_cycles;
        g0 = got_q.size();
    endtask

    vec_t vecs[6];
    logic [7:0] hello[5];
    logic [7:0] exp_q[$];

    initial begin
        int t0;
        int t1;
        int exp_ferr;

        vecs[0] = '{8'h41, 1'b1, 1, 8'h41, 0};
        vecs[1] = '{8'hA5, 1'b0, 0, 8'h00, 1};
        vecs[2] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
        vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[4] = '{8'h00, 1'b0, 0, 8'h00, 1};
        vecs[5] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        hello   = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_ferr",  32'(frame_err), 32'd0);
        check("rst_ovr",   32'(overrun),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Divider constants and default tick period
        check("div_default", uart_tick_div(100, 115200, 16), 32'd54);
        check("div_bench",   uart_tick_div(CLK_MHZ, BAUD, OS), 32'd6);
        t0 = -1;
        t1 = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (def_tick) begin
                if (t0 < 0) t0 = c;
                else if (t1 < 0) t1 = c;
            end
        end
        check("tick_period_default", 32'(t1 - t0), 32'd54);
        @(posedge clk);
        #1;

        // Table-driven single frames, consumer always ready
        for (int i = 0; i < 6; i++) begin
            snap();
            send_frame(vecs[i].data, vecs[i].stop_bit, CPB);
            cyc(3 * CPB);
            check($sformatf("tbl%0d_bytes", i), 32'(got_q.size() - g0), 32'(vecs[i].exp_bytes));
            check($sformatf("tbl%0d_vcyc", i), 32'(valid_cycles - v0), 32'(vecs[i].exp_bytes));
            if (vecs[i].exp_bytes == 1 && got_q.size() > g0)
                check($sformatf("tbl%0d_data", i), 32'(got_q[g0]), 32'(vecs[i].exp_data));
            check($sformatf("tbl%0d_ferr", i), 32'(ferr_cycles - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("tbl%0d_ovr", i), 32'(ovr_cycles - o0), 32'd0);
        end

        // Back-to-back frames
        snap();
        for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1, CPB);
        cyc(3 * CPB);
        check("hello_count", 32'(got_q.size() - g0), 32'd5);
        for (int i = 0; i < 5; i++)
            if (got_q.size() > g0 + i)
                check($sformatf("hello_%0d", i), 32'(got_q[g0 + i]), 32'(hello[i]));

        // Short low glitch rejected, then normal frame
        snap();
        rx = 1'b0;
        cyc(GLITCH);
        rx = 1'b1;
        cyc(2 * CPB);
        check("glitch_valid", 32'(valid_cycles - v0), 32'd0);
        check("glitch_ferr",  32'(ferr_cycles - f0),  32'd0);
        send_frame(8'h55, 1'b1, CPB);
        cyc(3 * CPB);
        check("glitch_next_count", 32'(got_q.size() - g0), 32'd1);
        if (got_q.size() > g0) check("glitch_next_data", 32'(got_q[g0]), 32'h55);

        // Overrun: consumer stalled across two bytes
        snap();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, CPB);
        cyc(2 * CPB);
        @(negedge clk);
        check("ovr_first_valid", 32'(out_valid), 32'd1);
        check("ovr_first_data",  32'(out_data),  32'h11);
        send_frame(8'h22, 1'b1, CPB);
        cyc(2 * CPB);
        @(negedge clk);
        check("ovr_pulses",    32'(ovr_cycles - o0), 32'd1);
        check("ovr_held_data", 32'(out_data), 32'h11);
        check("ovr_held_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cyc(2);
        @(negedge clk);
        check("ovr_drained_valid", 32'(out_valid), 32'd0);
        check("ovr_accept_count", 32'(got_q.size() - g0), 32'd1);
        if (got_q.size() > g0) check("ovr_accept_data", 32'(got_q[g0]), 32'h11);
        @(posedge clk);
        #1;

        // Reset in the middle of data bit 3 with a byte pending
        out_ready = 1'b0;
        send_frame(8'h5A, 1'b1, CPB);
        cyc(CPB);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 3; i++) send_bit(1'(8'h7E >> i), CPB);
        rx = 1'b1;
        cyc(CPB / 2);
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_data",  32'(out_data),  32'h5A);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1);
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data",  32'(out_data),  32'd0);
        check("midrst_ferr",  32'(frame_err), 32'd0);
        check("midrst_ovr",   32'(overrun),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        snap();
        cyc(12 * CPB);
        check("postrst_valid", 32'(valid_cycles - v0), 32'd0);
        send_frame(8'h81, 1'b1, CPB);
        cyc(3 * CPB);
        check("postrst_count", 32'(got_q.size() - g0), 32'd1);
        if (got_q.size() > g0) check("postrst_data", 32'(got_q[g0]), 32'h81);

        // Randomized frames against a scoreboard of well-formed bytes
        snap();
        exp_q.delete();
        exp_ferr = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            logic       ok;
            int         cpb;
            d   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 5) != 0);
            cpb = $urandom_range(95, 99);
            send_frame(d, ok, cpb);
            if (ok) begin
                exp_q.push_back(d);
                cyc($urandom_range(0, CPB));
            end else begin
                exp_ferr++;
                cyc(CPB + $urandom_range(0, CPB));
            end
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        cyc(3 * CPB);
        check("rand_count", 32'(got_q.size() - g0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (got_q.size() > g0 + i)
                check($sformatf("rand_%0d", i), 32'(got_q[g0 + i]), 32'(exp_q[i]));
        check("rand_ferr", 32'(ferr_cycles - f0), 32'(exp_ferr));
        check("rand_ovr",  32'(ovr_cycles - o0),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 SHALL have parameter CLK_FREQ_MHZ, default 100, system clock frequency in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; even, at least 8.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port out_valid  output  1  received byte available.
REQ-008 SHALL have port out_ready  input  1  consumer (RX FIFO of tl_ul_uart) accepts byte.
REQ-009 SHALL have port out_data  output  8  received byte, LSB first on the line.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: byte completed while holding register full.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-013 SHALL generate a sample tick every DIV = CLK_FREQ_MHZ*1000000/(BAUD_RATE*OVERSAMPLE) cycles, integer-truncated (54 at defaults), counter wrapping DIV-1 -> 0.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: on a tick with synchronized rx low -> START; sample counter cleared.
REQ-016 START: at tick OVERSAMPLE/2, majority vote of ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 computed; majority high -> IDLE (glitch rejected, no output); low -> DATA at end of bit.
REQ-017 DATA: each of 8 bits decided by the same 3-sample majority around mid-bit, shifted in LSB first; a 3-bit counter counts bits 0..7; after bit 7 -> STOP.
REQ-018 STOP: majority high at mid-bit -> byte complete, go to IDLE immediately (not waiting end of bit); majority low -> frame_err pulse, byte discarded, -> BREAK.
REQ-019 BREAK: remain until synchronized rx high on a tick, then -> IDLE.
REQ-020 On byte complete, out_data/out_valid SHALL update on the next clock edge; out_valid held until a cycle with out_valid && out_ready.
REQ-021 out_data SHALL be stable while out_valid is high and not yet accepted.
REQ-022 Byte complete while out_valid high and out_ready low: overrun pulse, new byte dropped, held byte kept.
REQ-023 Byte complete in the same cycle as out_valid && out_ready: old byte accepted, new byte loaded, out_valid stays high, no overrun.
REQ-024 frame_err and overrun SHALL each be high for exactly one cycle per event.

Reset
REQ-025 Reset SHALL set state IDLE, tick and sample/bit counters 0, synchronizer flops 1, out_valid 0, out_data 8'h00, frame_err 0, overrun 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame without output; after release, the remaining bits of that frame produce no valid output unless a high-to-low transition is seen from IDLE.

Structure
REQ-027 A shared package uart_pkg SHALL hold the state enum (uart_rx_state_t) and the divider constant function used by both RX and TX paths.
REQ-028 Tick generation SHALL be a sub-module uart_tick_gen (parameters CLK_FREQ_MHZ, BAUD_RATE, OVERSAMPLE; ports clk, reset, tick), reusable by the TX path.

Verification
REQ-029 Send 0x41 at 868 cycles/bit, out_ready held high -> out_valid one-cycle pulse, out_data 0x41, no frame_err/overrun.
REQ-030 Send 0x48,0x45,0x4C,0x4C,0x4F back-to-back, out_ready high -> five bytes in order, each exactly once.
REQ-031 rx low for 200 cycles then high -> no out_valid, state back to IDLE, next 0x55 received correctly.
REQ-032 Send 0xA5 with stop bit low, then line high -> frame_err one pulse, no out_valid; following 0x3C received correctly.
REQ-033 out_ready low, send 0x11 then 0x22 -> out_data 0x11 held, overrun one pulse at second stop; raise out_ready -> 0x11 accepted, out_valid drops.
REQ-034 Assert reset for 2 cycles mid data bit 3 of 0x7E -> all outputs at reset values, no byte output; next 0x81 received correctly.
